note_tone_gen: RTL
==================

# note_tone_gen

Square-wave tone generator that sits directly downstream of the note sequencer. It consumes the 4-bit semitone code (0 = low C … 12 = high C, 13–15 = rest) and converts it to a 50 % duty square wave on `wave_out` for the audio output stage. Pitch changes and rests take effect only at full-period boundaries, so the output never produces a runt pulse.

## Interface
- `CNT_W`, 16: width of the half-period counter; must hold the largest table entry, 19111.
- `clk` input 1: system clock, 10 MHz; the pitch table is computed for this frequency.
- `n_rst` input 1: asynchronous, active-low reset.
- `note_in` input 4: semitone code from the sequencer; 0–12 valid, 13–15 rest (sequencer idle code is 4'b1111).
- `octave` input 2: upward octave shift 0–3; half-period is right-shifted by this amount.
- `wave_out` output 1: registered square wave; reset 0.
- `playing` output 1: high whenever the FSM is not IDLE; reset 0.
- `period_start` output 1: one-cycle pulse coincident with each rising edge of `wave_out`; reset 0.

## Operation
- Half-period table in clk cycles, index 0..12: 19111, 18039, 17026, 16071, 15169, 14317, 13514, 12755, 12039, 11364, 10726, 10124, 9556.
- `half = table[note_in] >> octave`, computed combinationally and loaded into the `cur_half` register only at load points.
- FSM states: IDLE, HIGH, LOW. `cnt` (CNT_W bits) counts clocks within the current half-period.
- IDLE:
  - `wave_out` = 0 and `cnt` = 0.
  - If `note_in` ≤ 12: go to HIGH, load `cur_half`, set `cnt` = 0, `wave_out` = 1, `period_start` = 1.
- HIGH:
  - `cnt` increments each clock.
  - At `cnt == cur_half-1`: go to LOW, `cnt` = 0, `wave_out` = 0.
  - Input changes are ignored in HIGH.
- LOW:
  - `cnt` increments each clock.
  - At `cnt == cur_half-1`, `note_in` and `octave` are sampled.
    - Valid note: go to HIGH, reload `cur_half`, set `cnt` = 0, `wave_out` = 1, `period_start` = 1.
    - Rest: go to IDLE, `cnt` = 0, `wave_out` stays 0.
  - Input changes are otherwise ignored in LOW.
- Boundary conditions:
  - A note change in mid-period completes the current full period at the old pitch.
  - A rest code in mid-period completes the current period, then the block goes silent.
  - A one-cycle rest pulse that does not coincide with a load point is invisible.
  - `octave` = 3 on code 12 gives `half` = 1194; the minimum supported `half` is ≥ 2 and is never reached.
  - A counter compare uses equality only; `cnt` never exceeds `cur_half-1`.
- Reset asserted at any time immediately forces IDLE, `cnt` = 0, `cur_half` = 0 and all outputs to 0, with no waiting for a period boundary.

## Timing
- Latency from IDLE: `note_in` valid at rising edge k means `wave_out` = 1 and `period_start` = 1 in the cycle following edge k.
- Each HIGH and LOW phase lasts exactly `cur_half` clocks, so the period is 2·`cur_half` clocks.
- `period_start` is high for exactly one clock per period.
- All outputs come directly from flops; there are no combinational paths from inputs to outputs.
- `playing` falls in the same cycle `wave_out` would have risen when a rest is sampled.

## Structure
- Package `synth_pkg` holds:
  - the note code constants (`NOTE_C_LO` = 0 … `NOTE_C_HI` = 12, `NOTE_REST` = 4'b1111);
  - the 13-entry half-period constant array for 10 MHz;
  - the `tone_state_t` enum {IDLE, HIGH, LOW}.
- Sub-module `tone_period_lut` is purely combinational: `note_in`, `octave` → `half` (CNT_W bits) plus `valid`. It is reusable by later voices.
- `note_tone_gen` holds the FSM, the counter and the `cur_half` register.

## Test plan
- Reset, then `note_in` = 15 held for 1000 cycles: `wave_out` = 0, `playing` = 0 and `period_start` = 0 throughout.
- `note_in` = 9, `octave` = 0 applied from IDLE:
  - `wave_out` high for exactly 11364 clocks, then low for 11364 clocks;
  - `period_start` pulses every 22728 clocks;
  - first pulse occurs one cycle after the sampling edge.
- `note_in` = 12, `octave` = 3: half-period is 1194 clocks. Changing to `note_in` = 0 mid-HIGH leaves the current period at 1194/1194 clocks, and the next period is 2388/2388 clocks.
- While playing code 4, switch `note_in` to 15 during LOW:
  - the period completes;
  - `wave_out` stays 0;
  - `playing` drops at the boundary;
  - no extra `period_start` pulse occurs.
- Assert `n_rst` in the middle of HIGH: `wave_out`, `playing` and `period_start` go to 0 asynchronously. After release with `note_in` = 2, the tone restarts at 17026-cycle half-periods.
- Drive the sequencer-like pattern (codes 0, 2, 4, 5, 7, 9, 11, 12, 15, each changing mid-period): every pitch change aligns to a `period_start` pulse, and no high or low phase is shorter than the smaller of the two adjacent half-periods.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared constants and types for the synth voice blocks.
// The half-period table is in clk cycles at 10 MHz.
package synth_pkg;

  localparam logic [3:0] NOTE_C_LO = 4'd0;
  localparam logic [3:0] NOTE_C_HI = 4'd12;
  localparam logic [3:0] NOTE_REST = 4'b1111;

  localparam int NUM_NOTES = 13;
  localparam int TABLE_W   = 16;

  localparam logic [TABLE_W-1:0] HALF_TABLE [NUM_NOTES] = '{
    16'd19111, 16'd18039, 16'd17026, 16'd16071, 16'd15169,
    16'd14317, 16'd13514, 16'd12755, 16'd12039, 16'd11364,
    16'd10726, 16'd10124, 16'd9556
  };

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } tone_state_t;

  function automatic logic is_note(input logic [3:0] code);
    return code <= NOTE_C_HI;
  endfunction

endpackage

// File: rtl/tone_period_lut.sv
// Combinational semitone/octave to half-period lookup.
// Rest codes return valid = 0 and half = 0.
module tone_period_lut
  import synth_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic [3:0]       note_in,
  input  logic [1:0]       octave,
  output logic [CNT_W-1:0] half,
  output logic             valid
);

  logic [TABLE_W-1:0] base;

  // Compare-based select keeps the 4-bit code from indexing past the table.
  always_comb begin
    base = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (note_in == 4'(i)) begin
        base = HALF_TABLE[i];
      end
    end
  end

  assign valid = is_note(note_in);
  assign half  = CNT_W'(base >> octave);

endmodule

// File: rtl/note_tone_gen.sv
// 50% duty square-wave tone generator; pitch and rest changes are
// only accepted at full-period boundaries so no runt pulses appear.
module note_tone_gen
  import synth_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] note_in,
  input  logic [1:0] octave,
  output logic       wave_out,
  output logic       playing,
  output logic       period_start
);

  tone_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cur_half;
  logic [CNT_W-1:0] half;
  logic             valid;
  logic             at_end;

  tone_period_lut #(.CNT_W(CNT_W)) u_lut (
    .note_in (note_in),
    .octave  (octave),
    .half    (half),
    .valid   (valid)
  );

  assign at_end = (cnt == cur_half - CNT_W'(1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      cur_half     <= '0;
      wave_out     <= 1'b0;
      playing      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      period_start <= 1'b0;
      case (state)
        IDLE: begin
          cnt      <= '0;
          wave_out <= 1'b0;
          if (valid) begin
            state        <= HIGH;
            cur_half     <= half;
            wave_out     <= 1'b1;
            playing      <= 1'b1;
            period_start <= 1'b1;
          end
        end
        HIGH: begin
          if (at_end) begin
            state    <= LOW;
            cnt      <= '0;
            wave_out <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        LOW: begin
          if (at_end) begin
            cnt <= '0;
            // The only point where a new pitch or a rest is accepted.
            if (valid) begin
              state        <= HIGH;
              cur_half     <= half;
              wave_out     <= 1'b1;
              period_start <= 1'b1;
            end else begin
              state   <= IDLE;
              playing <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          wave_out <= 1'b0;
          playing  <= 1'b0;
        end
      endcase
    end
  end

endmodule
